// File: rtl/scenario_loader.sv
// Scenario loader: streams per-sprite position/velocity records from a fixed ROM
// and mirrors them into registered arrays. Optional velocity jitter: SCENARIO_JITTER_EN.
module scenario_loader #(
    parameter int SPRITES    = 4,
    parameter int DIMENSIONS = 2,
    parameter int WIDTH      = 32,
    parameter int SCENARIOS  = 8,
    parameter int AUTOLOAD   = 1,
    localparam int IW        = (SPRITES > 1) ? $clog2(SPRITES) : 1
) (
    input  logic                                          clock_162,
    input  logic                                          rst_n,
    input  logic [15:0]                                   sel,
    input  logic                                          load,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [IW-1:0]                                 out_idx,
    output logic [DIMENSIONS-1:0][WIDTH-1:0]              out_loc,
    output logic [DIMENSIONS-1:0][WIDTH-1:0]              out_vel,
    output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] loc_q,
    output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] vel_q,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          sel_err
);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_STREAM, S_DONE} state_t;
    typedef logic [DIMENSIONS-1:0][WIDTH-1:0] rec_t;

    localparam logic [WIDTH-1:0] C_MAG = WIDTH'(32'h0100_0000);
    localparam logic [WIDTH-1:0] V_MAG = WIDTH'(32'h0010_0000);

    // Sign tables: 2-bit code per (sprite, axis) at position 2*(2*i+d); 01=+1, 11=-1, 00=0.
    localparam logic [15:0] POS_A = 16'b1101_0111_1111_0101;
    localparam logic [15:0] POS_B = 16'b0011_0001_1100_0100;
    localparam logic [15:0] VEL_1 = 16'b1100_0100_1100_0100;
    localparam logic [15:0] VEL_2 = 16'b0100_1100_0011_0001;
    localparam logic [15:0] VEL_3 = 16'b1100_0100_0001_0011;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [15:0]       sel_q;
    logic              auto_pend;

    function automatic logic [WIDTH-1:0] rom_val(input logic [15:0] s, input int i,
                                                 input int d, input logic vel);
        logic [15:0]      tbl;
        logic [1:0]       code;
        logic [WIDTH-1:0] mag;
        tbl     = '0;
        code    = 2'b00;
        mag     = vel ? V_MAG : C_MAG;
        rom_val = '0;
        if (int'(s) < SCENARIOS && int'(s) < 4 && i < 4 && d < 2) begin
            unique case ({vel, s[1:0]})
                3'b000, 3'b001: tbl = POS_A;
                3'b010, 3'b011: tbl = POS_B;
                3'b100:         tbl = '0;
                3'b101:         tbl = VEL_1;
                3'b110:         tbl = VEL_2;
                3'b111:         tbl = VEL_3;
            endcase
            code = 2'(tbl >> (2 * (2 * i + d)));
            if (code == 2'b01)      rom_val = mag;
            else if (code == 2'b11) rom_val = '0 - mag;
        end
    endfunction

    function automatic rec_t rom_rec(input logic [15:0] s, input int i, input logic vel);
        for (int d = 0; d < DIMENSIONS; d++) rom_rec[d] = rom_val(s, i, d, vel);
    endfunction

`ifdef SCENARIO_JITTER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock_162) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Nonzero components get an offset in -8..+7; zero components stay exactly zero.
    function automatic rec_t apply_jitter(input rec_t r);
        logic signed [4:0] j;
        j = $signed({1'b0, lfsr[3:0]}) - 5'sd8;
        for (int d = 0; d < DIMENSIONS; d++)
            apply_jitter[d] = (r[d] != '0) ? r[d] + {{(WIDTH-5){j[4]}}, j} : r[d];
    endfunction
`else
    function automatic rec_t apply_jitter(input rec_t r);
        apply_jitter = r;
    endfunction
`endif

    always_ff @(posedge clock_162) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            sel_q     <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_loc   <= '0;
            out_vel   <= '0;
            // NOTE: the result arrays are reset on purpose; an aborted load must not leave stale sprites.
            loc_q     <= '0;
            vel_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sel_err   <= 1'b0;
            auto_pend <= (AUTOLOAD != 0);
        end else begin
            // NOTE: default-low assignment makes done a single-cycle pulse without extra logic.
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (load || auto_pend) begin
                        sel_q     <= sel;
                        auto_pend <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    idx       <= '0;
                    out_idx   <= '0;
                    sel_err   <= (int'(sel_q) >= SCENARIOS);
                    out_loc   <= rom_rec(sel_q, 0, 1'b0);
                    out_vel   <= apply_jitter(rom_rec(sel_q, 0, 1'b1));
                    out_valid <= 1'b1;
                    state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (out_valid && out_ready) begin
                        loc_q[idx] <= out_loc;
                        vel_q[idx] <= out_vel;
                        if (idx == IW'(SPRITES - 1)) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            out_idx <= idx + 1'b1;
                            out_loc <= rom_rec(sel_q, int'(idx) + 1, 1'b0);
                            out_vel <= apply_jitter(rom_rec(sel_q, int'(idx) + 1, 1'b1));
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scenario_loader.sv
// Self-checking bench for scenario_loader: directed and randomized loads checked
// against a scenario model written from the sprite layouts.
module tb_scenario_loader;

    localparam int SP  = 4;
    localparam int DM  = 2;
    localparam int WD  = 32;
    localparam int NSC = 8;
    localparam int CV  = 'h0100_0000;
    localparam int VV  = 'h0010_0000;

    typedef logic [DM-1:0][WD-1:0] rec_t;
    typedef logic [SP-1:0][DM-1:0][WD-1:0] arr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sel;
    logic        load;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_idx;
    rec_t        out_loc, out_vel;
    arr_t        loc_q, vel_q;
    logic        busy, done, sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scenario_loader #(.SPRITES(SP), .DIMENSIONS(DM), .WIDTH(WD), .SCENARIOS(NSC), .AUTOLOAD(1)) dut (
        .clock_162(clk), .rst_n(rst_n), .sel(sel), .load(load),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_loc(out_loc), .out_vel(out_vel), .loc_q(loc_q), .vel_q(vel_q),
        .busy(busy), .done(done), .sel_err(sel_err)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sprite layouts expressed as unit multipliers of C (positions) and V (velocities).
    function automatic logic [WD-1:0] m_loc(input int s, input int i, input int d);
        int x, y;
        if (s >= NSC || s > 3 || i > 3 || d > 1) return '0;
        if (s < 2) begin
            x = (i == 0 || i == 3) ? 1 : -1;
            y = (i == 0 || i == 2) ? 1 : -1;
        end else begin
            x = (i == 2) ? 1 : (i == 3) ? -1 : 0;
            y = (i == 0) ? 1 : (i == 1) ? -1 : 0;
        end
        return WD'((d == 0 ? x : y) * CV);
    endfunction

    function automatic logic [WD-1:0] m_vel(input int s, input int i, input int d);
        int x, y;
        x = 0;
        y = 0;
        if (s >= NSC || s > 3 || i > 3 || d > 1) return '0;
        if (s == 1) y = (i % 2 == 0) ? 1 : -1;
        if (s >= 2) begin
            x = (i == 0) ? 1 : (i == 1) ? -1 : 0;
            y = (i == 2) ? -1 : (i == 3) ? 1 : 0;
            if (s == 3) begin
                x = -x;
                y = -y;
            end
        end
        return WD'((d == 0 ? x : y) * VV);
    endfunction

    function automatic rec_t m_rec(input int s, input int i, input bit vel);
        rec_t r;
        for (int d = 0; d < DM; d++) r[d] = vel ? m_vel(s, i, d) : m_loc(s, i, d);
        return r;
    endfunction

    task automatic check_vel(input string tag, input rec_t obs, input rec_t exp);
`ifdef SCENARIO_JITTER_EN
        bit ok = 1'b1;
        for (int d = 0; d < DM; d++) begin
            int diff = int'($signed(obs[d] - exp[d]));
            if (exp[d] == '0) ok &= (obs[d] == '0);
            else              ok &= (diff >= -8 && diff <= 8);
        end
        check(tag, ok, 1'b1);
`else
        check(tag, obs, exp);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int s);
        sel  = 16'(s);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Follows a load whose accepting edge has just passed. mode: 0 ready high, 1 toggle, 2 random.
    task automatic run_stream(input int s, input int mode, input bit disturb);
        int xfer = 0;
        int n    = 1;
        int tog  = 0;
        bit seen = 1'b0;
        check("busy_after_load", busy, 1'b1);
        while (!seen && n < 200) begin
            if (out_valid) begin
                check("rec_idx", out_idx, xfer);
                check("rec_loc", out_loc, m_rec(s, xfer, 1'b0));
                check_vel("rec_vel", out_vel, m_rec(s, xfer, 1'b1));
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (tog % 2 == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                tog++;
                if (disturb && xfer == 1) begin
                    load = 1'b1;
                    sel  = 16'd3;
                end else begin
                    load = 1'b0;
                    if (!disturb) sel = 16'($urandom_range(0, 15));
                end
                if (out_ready) xfer++;
            end
            if (done) begin
                seen = 1'b1;
                check("done_xfers", xfer, SP);
                check("done_busy", busy, 1'b0);
                check("done_valid", out_valid, 1'b0);
                check("done_sel_err", sel_err, (s >= NSC));
                if (mode == 0) check("done_latency", n, SP + 2);
            end else begin
                step();
                n++;
            end
        end
        check("done_seen", seen, 1'b1);
        load      = 1'b0;
        out_ready = 1'b1;
        step();
        check("done_single", done, 1'b0);
        for (int i = 0; i < SP; i++) begin
            check("arr_loc", loc_q[i], m_rec(s, i, 1'b0));
            check_vel("arr_vel", vel_q[i], m_rec(s, i, 1'b1));
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_sel_err"}, sel_err, 1'b0);
        check({tag, "_idx"}, out_idx, 2'd0);
        check({tag, "_out_loc"}, out_loc, '0);
        check({tag, "_out_vel"}, out_vel, '0);
        check({tag, "_loc_q"}, loc_q, '0);
        check({tag, "_vel_q"}, vel_q, '0);
    endtask

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        sel       = 16'd0;
        out_ready = 1'b1;
        repeat (3) step();
        check_cleared("reset");

        // Autoload with sel=0 on the first cycle out of reset.
        rst_n = 1'b1;
        step();
        run_stream(0, 0, 1'b0);
        check("loc_q1", loc_q[1], 64'hFF00_0000_FF00_0000);

        do_load(2);
        run_stream(2, 1, 1'b0);
        check("vel_q3", vel_q[3], 64'h0010_0000_0000_0000);

        do_load(9);
        run_stream(9, 2, 1'b0);

        do_load(1);
        run_stream(1, 0, 1'b1);

        for (int k = 0; k < 4; k++) begin
            int s = $urandom_range(0, 9);
            do_load(s);
            run_stream(s, $urandom_range(0, 2), 1'b0);
        end

        // Reset in the middle of a stream, then the autoload restarts with sel=2.
        do_load(0);
        repeat (3) step();
        check("pre_abort_idx", out_idx, 2'd2);
        rst_n = 1'b0;
        sel   = 16'd2;
        step();
        check_cleared("abort");
        rst_n = 1'b1;
        step();
        run_stream(2, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
